dcache_ctrl: RTL and testbench

- Controller that sequences the 2-way, 16-set, 256-bit-line dcache SRAM (dcache_sram) between the CPU load/store port and the off-chip data memory.
- Decodes CPU addresses, resolves hits in the same cycle and stalls the CPU on a miss.
- On a miss, writes back a dirty LRU victim, fetches the missing line and refills the SRAM, then replays the access.
- Sits between the CPU MEM stage and the data memory model; owns every dcache_sram control input.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_word_merge.sv | 17 +
 rtl/dcache_ctrl.sv | 107 ++++++++++
 tb/tb_dcache_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state type, address/tag field positions and line geometry for the dcache controller
package dcache_pkg;
    localparam int ADDR_W         = 32;
    localparam int LINE_W         = 256;
    localparam int IDX_W          = 4;
    localparam int TAG_W          = 23;
    localparam int WORDS_PER_LINE = 8;
    localparam int TAG_LSB        = 9;
    localparam int IDX_LSB        = 5;
    localparam int WORD_LSB       = 2;
    localparam int VALID_BIT      = 24;
    localparam int DIRTY_BIT      = 23;
    typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, ALLOCATE, REFILL} state_t;
endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: reads one 32-bit word of a line and builds the line with that word replaced
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    input  logic [2:0]        sel,
    input  logic [31:0]       wr_word,
    input  logic              wen,
    output logic [31:0]       rd_word,
    output logic [LINE_W-1:0] merged
);
    always_comb begin
        merged = line;
        if (wen) merged[{sel, 5'b0} +: 32] = wr_word;
    end
    assign rd_word = line[{sel, 5'b0} +: 32];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequences the 2-way dcache SRAM between the CPU port and data memory (write-back, write-allocate)
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_wen_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    output logic                sram_enable_o,
    output logic                sram_write_o,
    output logic [IDX_W-1:0]    sram_addr_o,
    output logic [TAG_W+1:0]    sram_tag_o,
    output logic [LINE_W-1:0]   sram_data_o,
    input  logic                sram_hit_i,
    input  logic [LINE_W-1:0]   sram_data_i,
    input  logic [TAG_W+1:0]    sram_victim_tag_i,
    input  logic [LINE_W-1:0]   sram_victim_data_i,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
);
    state_t state, state_nx;
    logic [TAG_W+1:0]  victim_tag;
    logic [LINE_W-1:0] victim_data, refill_line, merge_src;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] fetch_addr, wb_addr;
    logic idle_hit, idle_miss, victim_dirty, addr_unused;
    assign cpu_tag      = cpu_addr_i[ADDR_W-1:TAG_LSB];
    assign idx          = cpu_addr_i[TAG_LSB-1:IDX_LSB];
    assign addr_unused  = ^cpu_addr_i[WORD_LSB-1:0];
    assign fetch_addr   = {cpu_tag, idx, {IDX_LSB{1'b0}}};
    assign wb_addr      = {victim_tag[TAG_W-1:0], idx, {IDX_LSB{1'b0}}};
    assign idle_hit     = state == IDLE && cpu_req_i && sram_hit_i;
    assign idle_miss    = state == IDLE && cpu_req_i && !sram_hit_i;
    assign victim_dirty = victim_tag[VALID_BIT] && victim_tag[DIRTY_BIT];
    assign cpu_stall_o   = cpu_req_i && (state != IDLE || !sram_hit_i);
    assign sram_enable_o = cpu_req_i || state == REFILL;
    assign sram_write_o  = (idle_hit && cpu_wen_i) || state == REFILL;
    assign sram_addr_o   = idx;
    assign sram_tag_o    = {1'b1, state == REFILL ? cpu_wen_i : 1'b1, cpu_tag};
    // One merge unit serves load select and store-hit merge in IDLE, and the refill merge in REFILL.
    assign merge_src     = state == REFILL ? refill_line : sram_data_i;
    dcache_word_merge u_merge (
        .line    (merge_src),
        .sel     (cpu_addr_i[IDX_LSB-1:WORD_LSB]),
        .wr_word (cpu_data_i),
        .wen     (cpu_wen_i),
        .rd_word (cpu_data_o),
        .merged  (sram_data_o)
    );
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      state_nx = idle_miss ? MISS : IDLE;
            MISS:      state_nx = victim_dirty ? WRITEBACK : ALLOCATE;
            WRITEBACK: state_nx = mem_ack_i ? ALLOCATE : WRITEBACK;
            ALLOCATE:  state_nx = mem_ack_i ? REFILL : ALLOCATE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            refill_line  <= '0;
            victim_tag   <= '0;
            victim_data  <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
        end else begin
            state <= state_nx;
            if (idle_hit && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
            if (idle_miss) begin
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
                victim_tag  <= sram_victim_tag_i;
                victim_data <= sram_victim_data_i;
            end
            if (state == MISS) begin
                mem_enable_o <= 1'b1;
                mem_write_o  <= victim_dirty;
                mem_addr_o   <= victim_dirty ? wb_addr : fetch_addr;
                if (victim_dirty) mem_data_o <= victim_data;
            end
            if (state == WRITEBACK && mem_ack_i) begin
                mem_write_o <= 1'b0;
                mem_addr_o  <= fetch_addr;
            end
            if (state == ALLOCATE && mem_ack_i) begin
                mem_enable_o <= 1'b0;
                refill_line  <= mem_data_i;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: dcache_ctrl with behavioural SRAM and memory, checked against a cache/memory reference model
module tb_dcache_ctrl;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic cpu_req_i = 1'b0, cpu_wen_i = 1'b0;
    logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o;
    logic cpu_stall_o, sram_enable_o, sram_write_o, sram_hit_i;
    logic [3:0] sram_addr_o;
    logic [24:0] sram_tag_o, sram_victim_tag_i;
    logic [255:0] sram_data_o, sram_data_i, sram_victim_data_i;
    logic mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0] mem_addr_o, hit_cnt_o, miss_cnt_o;
    logic [255:0] mem_data_o, mem_data_i = '0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_wen_i(cpu_wen_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_hit_i(sram_hit_i), .sram_data_i(sram_data_i), .sram_victim_tag_i(sram_victim_tag_i),
        .sram_victim_data_i(sram_victim_data_i), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    int n_chk = 0, n_fail = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction
    function automatic logic [255:0] def_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = def_word(la + 32'(w * 4));
        return l;
    endfunction

    // behavioural 2-way LRU SRAM (environment)
    logic [24:0]  s_tag [16][2];
    logic [255:0] s_dat [16][2];
    logic         s_lru [16];
    logic h0, h1, sway;
    always_comb begin
        h0 = s_tag[sram_addr_o][0][24] && s_tag[sram_addr_o][0][22:0] == sram_tag_o[22:0];
        h1 = s_tag[sram_addr_o][1][24] && s_tag[sram_addr_o][1][22:0] == sram_tag_o[22:0];
        sway = h0 ? 1'b0 : h1 ? 1'b1 : s_lru[sram_addr_o];
        sram_hit_i = sram_enable_o && (h0 || h1);
        sram_data_i = h1 ? s_dat[sram_addr_o][1] : s_dat[sram_addr_o][0];
        sram_victim_tag_i = s_tag[sram_addr_o][s_lru[sram_addr_o]];
        sram_victim_data_i = s_dat[sram_addr_o][s_lru[sram_addr_o]];
    end
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                s_tag[i][0] <= '0; s_tag[i][1] <= '0;
                s_dat[i][0] <= '0; s_dat[i][1] <= '0;
                s_lru[i] <= 1'b0;
            end
        end else if (sram_enable_o) begin
            if (sram_write_o) begin
                s_tag[sram_addr_o][sway] <= sram_tag_o;
                s_dat[sram_addr_o][sway] <= sram_data_o;
            end
            if (sram_write_o || h0 || h1) s_lru[sram_addr_o] <= !sway;
        end
    end

    // line memory with programmable latency; also checks request stability while waiting
    logic [255:0] mem_lines [logic [31:0]];
    logic mem_ack_q = 1'b0, stray_ack = 1'b0, hold_wr = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [255:0] hold_data = '0;
    logic [31:0] wb_log [$];
    int mem_lat = 1, lat_cnt = 0, wr_cycles = 0;
    assign mem_ack_i = mem_ack_q | stray_ack;
    always @(negedge clk_i) begin
        if (rst_i) begin
            mem_ack_q <= 1'b0;
            lat_cnt <= 0;
        end else if (mem_ack_q) begin
            mem_ack_q <= 1'b0;
            lat_cnt <= 0;
        end else if (mem_enable_o) begin
            if (mem_write_o) wr_cycles <= wr_cycles + 1;
            if (lat_cnt > 0) begin
                check("mem_addr_hold", mem_addr_o, hold_addr);
                check("mem_write_hold", mem_write_o, hold_wr);
                if (mem_write_o) check("mem_data_hold", mem_data_o == hold_data, 1);
            end
            hold_addr <= mem_addr_o;
            hold_data <= mem_data_o;
            hold_wr <= mem_write_o;
            if (lat_cnt == mem_lat - 1) begin
                mem_ack_q <= 1'b1;
                lat_cnt <= 0;
                if (mem_write_o) begin
                    mem_lines[mem_addr_o] = mem_data_o;
                    wb_log.push_back(mem_addr_o);
                end else
                    mem_data_i <= mem_lines.exists(mem_addr_o) ? mem_lines[mem_addr_o] : def_line(mem_addr_o);
            end else
                lat_cnt <= lat_cnt + 1;
        end
    end

    // reference model: architectural memory words plus per-set LRU tag lists (front = least recent)
    logic [31:0] ref_words [logic [31:0]];
    bit dirty_line [logic [31:0]];
    logic [22:0] lru_q [16][$];
    int exp_hits = 0, exp_miss = 0;
    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic miss, output logic [31:0] rdata, output int n_wb, output logic [31:0] wba);
        logic [3:0] s;
        logic [22:0] t;
        logic [31:0] va;
        int f[$];
        s = a[8:5];
        t = a[31:9];
        n_wb = 0;
        wba = '0;
        f = lru_q[s].find_first_index(x) with (x == t);
        miss = f.size() == 0;
        if (!miss) lru_q[s].delete(f[0]);
        else begin
            exp_miss++;
            if (lru_q[s].size() == 2) begin
                va = {lru_q[s].pop_front(), s, 5'b0};
                if (dirty_line.exists(va)) begin
                    n_wb = 1;
                    wba = va;
                    dirty_line.delete(va);
                end
            end
        end
        lru_q[s].push_back(t);
        exp_hits++;
        if (w) begin
            ref_words[{a[31:2], 2'b00}] = d;
            dirty_line[{a[31:5], 5'b0}] = 1'b1;
        end
        rdata = ref_words.exists({a[31:2], 2'b00}) ? ref_words[{a[31:2], 2'b00}] : def_word(a);
    endtask

    // called at a negedge; returns at a negedge after the completing edge with the request dropped
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d, output logic miss_seen,
                             output int ncyc, output logic [31:0] rdata, output int n_wb, output logic [31:0] wba);
        int wb0;
        wb0 = wb_log.size();
        cpu_req_i = 1'b1; cpu_wen_i = w; cpu_addr_i = a; cpu_data_i = d;
        #1;
        ncyc = 0;
        while (cpu_stall_o && ncyc < 400) begin
            ncyc++;
            @(negedge clk_i); #1;
        end
        if (ncyc >= 400) check("stall_timeout", ncyc, 0);
        miss_seen = ncyc != 0;
        rdata = cpu_data_o;
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        n_wb = wb_log.size() - wb0;
        wba = n_wb > 0 ? wb_log[wb0] : '0;
    endtask

    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, output logic miss,
                       output int ncyc, output logic [31:0] rdata, output int onw, output logic [31:0] owa);
        logic em;
        logic [31:0] ed, ewa;
        int enw;
        model_step(w, a, d, em, ed, enw, ewa);
        do_access(w, a, d, miss, ncyc, rdata, onw, owa);
        check("model_miss", miss, em);
        if (!w) check("model_load_data", rdata, ed);
        check("model_wb_count", onw, enw);
        if (enw > 0) check("model_wb_addr", owa, ewa);
        check("model_hit_cnt", hit_cnt_o, exp_hits);
        check("model_miss_cnt", miss_cnt_o, exp_miss);
    endtask

    typedef struct {
        logic w; logic [31:0] a; logic [31:0] d;
        logic exp_miss; logic [31:0] exp_data; int exp_wb; logic [31:0] exp_wb_addr; int exp_cyc;
    } vec_t;
    vec_t vt [11];

    task automatic apply_row(input int i);
        logic miss;
        int ncyc, nwb, wr0;
        logic [31:0] rdata, wba;
        wr0 = wr_cycles;
        run(vt[i].w, vt[i].a, vt[i].d, miss, ncyc, rdata, nwb, wba);
        check($sformatf("row%0d_miss", i), miss, vt[i].exp_miss);
        if (!vt[i].w) check($sformatf("row%0d_data", i), rdata, vt[i].exp_data);
        check($sformatf("row%0d_wb", i), nwb, vt[i].exp_wb);
        if (vt[i].exp_wb > 0) check($sformatf("row%0d_wb_addr", i), wba, vt[i].exp_wb_addr);
        else check($sformatf("row%0d_no_write", i), wr_cycles - wr0, 0);
        check($sformatf("row%0d_stall_cycles", i), ncyc, vt[i].exp_cyc);
    endtask

    initial begin
        logic miss, em;
        logic [31:0] rdata, wba, ed;
        logic [255:0] l;
        int ncyc, nwb, enw;
        l = def_line(32'h100);
        l[63:32] = 32'hDEAD_BEEF;
        mem_lines[32'h100] = l;
        ref_words[32'h104] = 32'hDEAD_BEEF;
        vt[0]  = '{1'b0, 32'h104, 32'h0,         1'b1, 32'hDEAD_BEEF, 0, 32'h0,   4};
        vt[1]  = '{1'b0, 32'h104, 32'h0,         1'b0, 32'hDEAD_BEEF, 0, 32'h0,   0};
        vt[2]  = '{1'b1, 32'h300, 32'hAAAA_0001, 1'b1, 32'h0,         0, 32'h0,   4};
        vt[3]  = '{1'b1, 32'h504, 32'hBBBB_0002, 1'b1, 32'h0,         1, 32'h100, 6};
        vt[4]  = '{1'b0, 32'h700, 32'h0,         1'b1, 32'hC0DE_0700, 1, 32'h300, 6};
        vt[5]  = '{1'b0, 32'h300, 32'h0,         1'b1, 32'hAAAA_0001, 1, 32'h500, 6};
        vt[6]  = '{1'b0, 32'h504, 32'h0,         1'b1, 32'hBBBB_0002, 0, 32'h0,   4};
        vt[7]  = '{1'b0, 32'h108, 32'h0,         1'b1, 32'h1234_5678, 0, 32'h0,   4};
        vt[8]  = '{1'b0, 32'h060, 32'h0,         1'b1, 32'hC0DE_0060, 0, 32'h0,   4};
        vt[9]  = '{1'b0, 32'h264, 32'h0,         1'b1, 32'hC0DE_0264, 0, 32'h0,   4};
        vt[10] = '{1'b0, 32'h468, 32'h0,         1'b1, 32'hC0DE_0468, 0, 32'h0,   4};

        repeat (3) @(negedge clk_i);
        check("rst_mem_enable", mem_enable_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o == '0, 1);
        check("rst_sram_write", sram_write_o, 0);
        check("rst_hit_cnt", hit_cnt_o, 0);
        check("rst_miss_cnt", miss_cnt_o, 0);
        check("rst_stall", cpu_stall_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 2; i++) apply_row(i);
        model_step(1'b1, 32'h108, 32'h1234_5678, em, ed, enw, wba);
        cpu_req_i = 1'b1; cpu_wen_i = 1'b1; cpu_addr_i = 32'h108; cpu_data_i = 32'h1234_5678;
        #1;
        check("store_hit_stall", cpu_stall_o, 0);
        check("store_hit_sram_write", sram_write_o, 1);
        check("store_hit_tag", sram_tag_o, 25'h180_0000);
        check("store_hit_word2", sram_data_o[95:64], 32'h1234_5678);
        check("store_hit_word1_kept", sram_data_o[63:32], 32'hDEAD_BEEF);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        check("store_hit_cnt", hit_cnt_o, exp_hits);
        for (int i = 2; i < 11; i++) apply_row(i);

        mem_lat = 10;
        run(1'b1, 32'h0A0, 32'h5555_0001, miss, ncyc, rdata, nwb, wba);
        check("lat10_clean_stall", ncyc, 13);
        run(1'b0, 32'h2A0, 32'h0, miss, ncyc, rdata, nwb, wba);
        check("lat10_clean_stall2", ncyc, 13);
        run(1'b0, 32'h4A0, 32'h0, miss, ncyc, rdata, nwb, wba);
        check("lat10_dirty_stall", ncyc, 24);
        check("lat10_wb_addr", wba, 32'h0A0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            mem_lat = 1 + int'($urandom_range(3));
            a = {21'b0, 2'($urandom_range(3)), ($urandom_range(1) == 1) ? 4'd2 : 4'd9, 3'($urandom_range(7)), 2'b00};
            run(1'($urandom_range(1)), a, $urandom, miss, ncyc, rdata, nwb, wba);
        end

        mem_lat = 10;
        run(1'b1, 32'h180, 32'h7777_0001, miss, ncyc, rdata, nwb, wba);
        run(1'b1, 32'h380, 32'h7777_0002, miss, ncyc, rdata, nwb, wba);
        cpu_req_i = 1'b1; cpu_wen_i = 1'b0; cpu_addr_i = 32'h580;
        ncyc = 0;
        while (!(mem_enable_o && mem_write_o) && ncyc < 50) begin
            ncyc++;
            @(negedge clk_i);
        end
        check("reached_writeback", mem_enable_o && mem_write_o, 1);
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        check("midrst_mem_enable", mem_enable_o, 0);
        check("midrst_mem_write", mem_write_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_hit_cnt", hit_cnt_o, 0);
        check("midrst_miss_cnt", miss_cnt_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        stray_ack = 1'b1;
        @(negedge clk_i);
        stray_ack = 1'b0;
        @(negedge clk_i);
        check("stray_ack_mem_enable", mem_enable_o, 0);
        check("stray_ack_sram_write", sram_write_o, 0);
        check("stray_ack_miss_cnt", miss_cnt_o, 0);
        do_access(1'b0, 32'h0001_0000, 32'h0, miss, ncyc, rdata, nwb, wba);
        check("post_rst_miss", miss, 1);
        check("post_rst_stall", ncyc, 13);
        check("post_rst_data", rdata, def_word(32'h0001_0000));
        check("post_rst_hit_cnt", hit_cnt_o, 1);
        check("post_rst_miss_cnt", miss_cnt_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
